// File: rtl/cpu_branch_predictor_if.sv
// Fetch lookup and execute update bundle for cpu_branch_predictor.
// master: fetch/execute side driving the PC and resolved outcomes.
// slave : the predictor answering lookups and absorbing updates.
interface cpu_branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            f_pred_taken;
    logic            f_target_hit;
    logic [XLEN-1:0] f_target_addr;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_branch;
    logic            upd_is_jump;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;

    modport master (
        output f_pc,
        input  f_pred_taken, f_target_hit, f_target_addr,
        output upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken, upd_target
    );

    modport slave (
        input  f_pc,
        output f_pred_taken, f_target_hit, f_target_addr,
        input  upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken, upd_target
    );
endinterface

// File: rtl/cpu_branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit bimodal counters.
// Lookup is combinational; updates from execute commit on the rising clock edge.
// Optional macro BRANCH_PRED_BYPASS_EN: forward a same-cycle update to the
// same index into the lookup so fetch sees the post-update entry immediately.
module cpu_branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic              r_valid   [ENTRIES];
    logic [TAG_W-1:0]  r_tag     [ENTRIES];
    logic [XLEN-1:0]   r_target  [ENTRIES];
    logic              r_is_jump [ENTRIES];
    logic [1:0]        r_ctr     [ENTRIES];

    logic [IDX_W-1:0]  w_f_idx;
    logic [TAG_W-1:0]  w_f_tag;
    logic [IDX_W-1:0]  w_u_idx;
    logic [TAG_W-1:0]  w_u_tag;
    logic              w_u_hit;
    logic              w_wr;
    logic              w_n_valid;
    logic [TAG_W-1:0]  w_n_tag;
    logic [XLEN-1:0]   w_n_target;
    logic              w_n_is_jump;
    logic [1:0]        w_n_ctr;
    logic              w_l_valid;
    logic [TAG_W-1:0]  w_l_tag;
    logic [XLEN-1:0]   w_l_target;
    logic              w_l_is_jump;
    logic [1:0]        w_l_ctr;
    logic              w_hit;
    logic              w_unused_bits;

    // Saturating 2-bit bimodal counter step
    function automatic logic [1:0] f_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

    assign w_f_idx = bp.f_pc[IDX_W+1:2];
    assign w_f_tag = bp.f_pc[IDX_W+2+TAG_W-1:IDX_W+2];
    assign w_u_idx = bp.upd_pc[IDX_W+1:2];
    assign w_u_tag = bp.upd_pc[IDX_W+2+TAG_W-1:IDX_W+2];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    // PC bits outside index/tag (alignment and high bits) are intentionally ignored
    assign w_unused_bits = ^{bp.f_pc, bp.upd_pc};

    // Next contents of the entry addressed by the update port
    always_comb begin
        w_wr        = 1'b0;
        w_n_valid   = r_valid[w_u_idx];
        w_n_tag     = r_tag[w_u_idx];
        w_n_target  = r_target[w_u_idx];
        w_n_is_jump = r_is_jump[w_u_idx];
        w_n_ctr     = r_ctr[w_u_idx];
        if (bp.upd_valid) begin
            if (bp.upd_is_jump) begin
                // Jumps are always taken: (re)install as strongly taken
                w_wr        = 1'b1;
                w_n_valid   = 1'b1;
                w_n_tag     = w_u_tag;
                w_n_target  = bp.upd_target;
                w_n_is_jump = 1'b1;
                w_n_ctr     = 2'b11;
            end else if (bp.upd_is_branch) begin
                if (w_u_hit) begin
                    w_wr        = 1'b1;
                    w_n_is_jump = 1'b0;
                    w_n_ctr     = f_ctr_next(r_ctr[w_u_idx], bp.upd_taken);
                    if (bp.upd_taken) begin
                        w_n_target = bp.upd_target;
                    end
                end else if (bp.upd_taken) begin
                    // Allocate on taken miss, evicting any aliased entry
                    w_wr        = 1'b1;
                    w_n_valid   = 1'b1;
                    w_n_tag     = w_u_tag;
                    w_n_target  = bp.upd_target;
                    w_n_is_jump = 1'b0;
                    w_n_ctr     = 2'b10;
                end
            end
        end
    end

    // Lookup of the fetch PC, optionally forwarding a same-index update
    always_comb begin
        w_l_valid   = r_valid[w_f_idx];
        w_l_tag     = r_tag[w_f_idx];
        w_l_target  = r_target[w_f_idx];
        w_l_is_jump = r_is_jump[w_f_idx];
        w_l_ctr     = r_ctr[w_f_idx];
`ifdef BRANCH_PRED_BYPASS_EN
        if (w_wr && (w_u_idx == w_f_idx)) begin
            w_l_valid   = w_n_valid;
            w_l_tag     = w_n_tag;
            w_l_target  = w_n_target;
            w_l_is_jump = w_n_is_jump;
            w_l_ctr     = w_n_ctr;
        end
`endif
        w_hit = !rst && w_l_valid && (w_l_tag == w_f_tag);
    end

    assign bp.f_target_hit  = w_hit;
    assign bp.f_pred_taken  = w_hit && (w_l_is_jump || w_l_ctr[1]);
    assign bp.f_target_addr = w_hit ? w_l_target : '0;

    // Table state: reset clears every entry in one cycle and wins over updates
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]   <= 1'b0;
                r_tag[i]     <= '0;
                r_target[i]  <= '0;
                r_is_jump[i] <= 1'b0;
                r_ctr[i]     <= 2'b01;
            end
        end else if (w_wr) begin
            r_valid[w_u_idx]   <= w_n_valid;
            r_tag[w_u_idx]     <= w_n_tag;
            r_target[w_u_idx]  <= w_n_target;
            r_is_jump[w_u_idx] <= w_n_is_jump;
            r_ctr[w_u_idx]     <= w_n_ctr;
        end
    end
endmodule

// File: tb/tb_cpu_branch_predictor.sv
// Self-checking bench for cpu_branch_predictor (ENTRIES=16, TAG_W=8).
// Directed vector table, hand-written same-cycle sequences, then random traffic
// compared against a table-of-records model built from the predictor rules.
module tb_cpu_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_branch_predictor_if #(.XLEN(32)) bp_if ();

    cpu_branch_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    typedef struct {
        bit          valid;
        int          tag;
        logic [31:0] tgt;
        bit          jmp;
        int          ctr;
    } ent_t;

    ent_t m_tab [16];

    typedef struct {
        bit          r;
        logic [31:0] pc;
        bit          v, br, jp, tk;
        logic [31:0] upc, utgt;
        bit          e_hit, e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[$];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 6) & 32'hFF);
    endfunction

    // Entry after applying one resolved outcome, straight from the predictor rules
    function automatic ent_t m_after(input ent_t e, input logic [31:0] pc, input bit v,
                                     input bit br, input bit jp, input bit tk,
                                     input logic [31:0] tgt);
        ent_t n;
        bit   hit;
        n   = e;
        hit = e.valid && (e.tag == tag_of(pc));
        if (v && jp) begin
            n.valid = 1; n.tag = tag_of(pc); n.tgt = tgt; n.jmp = 1; n.ctr = 3;
        end else if (v && br) begin
            if (hit) begin
                n.ctr = tk ? ((e.ctr + 1 > 3) ? 3 : e.ctr + 1) : ((e.ctr - 1 < 0) ? 0 : e.ctr - 1);
                n.jmp = 0;
                if (tk) n.tgt = tgt;
            end else if (tk) begin
                n.valid = 1; n.tag = tag_of(pc); n.tgt = tgt; n.jmp = 0; n.ctr = 2;
            end
        end
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_tab[i].valid = 0; m_tab[i].tag = 0; m_tab[i].tgt = '0;
            m_tab[i].jmp = 0;   m_tab[i].ctr = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [31:0] s_hit, s_tk, s_tgt;

    // One cycle: drive, compare against the model before the edge, then commit the model
    task automatic step(input bit r, input logic [31:0] pc, input bit v, input bit br,
                        input bit jp, input bit tk, input logic [31:0] upc,
                        input logic [31:0] utgt);
        ent_t        post, seen;
        bit          e_hit, e_tk;
        logic [31:0] e_tgt;
        rst                 = r;
        bp_if.f_pc          = pc;
        bp_if.upd_valid     = v;
        bp_if.upd_is_branch = br;
        bp_if.upd_is_jump   = jp;
        bp_if.upd_taken     = tk;
        bp_if.upd_pc        = upc;
        bp_if.upd_target    = utgt;
        #3;
        s_hit = 32'(bp_if.f_target_hit);
        s_tk  = 32'(bp_if.f_pred_taken);
        s_tgt = bp_if.f_target_addr;
        post = m_after(m_tab[idx_of(upc)], upc, v, br, jp, tk, utgt);
        seen = m_tab[idx_of(pc)];
`ifdef BRANCH_PRED_BYPASS_EN
        if (idx_of(upc) == idx_of(pc)) seen = post;
`endif
        e_hit = !r && seen.valid && (seen.tag == tag_of(pc));
        e_tk  = e_hit && (seen.jmp || seen.ctr >= 2);
        e_tgt = e_hit ? seen.tgt : 32'h0;
        chk("model_hit", s_hit, 32'(e_hit));
        chk("model_taken", s_tk, 32'(e_tk));
        chk("model_target", s_tgt, e_tgt);
        @(posedge clk);
        if (r) m_reset();
        else   m_tab[idx_of(upc)] = post;
        #1;
    endtask

    task automatic add(input bit r, input logic [31:0] pc, input bit v, input bit br,
                       input bit jp, input bit tk, input logic [31:0] upc,
                       input logic [31:0] utgt, input bit eh, input bit et,
                       input logic [31:0] eg);
        vec_t x;
        x.r = r; x.pc = pc; x.v = v; x.br = br; x.jp = jp; x.tk = tk;
        x.upc = upc; x.utgt = utgt; x.e_hit = eh; x.e_tk = et; x.e_tgt = eg;
        vecs.push_back(x);
    endtask

    // Lookup-only row and update row (lookup at 0x104, an index never written)
    task automatic look(input logic [31:0] pc, input bit eh, input bit et, input logic [31:0] eg);
        add(0, pc, 0, 0, 0, 0, 32'h0, 32'h0, eh, et, eg);
    endtask

    task automatic upd(input bit br, input bit jp, input bit tk, input logic [31:0] upc,
                       input logic [31:0] utgt);
        add(0, 32'h104, 1, br, jp, tk, upc, utgt, 0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] rpc, rupc, rtgt;
        m_reset();
        bp_if.f_pc = '0; bp_if.upd_valid = 0; bp_if.upd_is_branch = 0;
        bp_if.upd_is_jump = 0; bp_if.upd_taken = 0; bp_if.upd_pc = '0; bp_if.upd_target = '0;

        add(1, 32'h100, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);   // during reset
        look(32'h100, 0, 0, 32'h0);                               // after reset
        upd(1, 0, 1, 32'h100, 32'h80);
        look(32'h100, 1, 1, 32'h80);                              // ctr 10
        upd(1, 0, 0, 32'h100, 32'h0);
        look(32'h100, 1, 0, 32'h80);                              // ctr 01
        for (int k = 0; k < 4; k++) upd(1, 0, 1, 32'h200, 32'h60);
        look(32'h200, 1, 1, 32'h60);                              // ctr 11
        upd(1, 0, 0, 32'h200, 32'h0);
        look(32'h200, 1, 1, 32'h60);                              // ctr 10
        upd(1, 0, 0, 32'h200, 32'h0);
        look(32'h200, 1, 0, 32'h60);                              // ctr 01
        upd(1, 0, 1, 32'h100, 32'h80);
        look(32'h100, 1, 1, 32'h80);
        upd(0, 1, 0, 32'h140, 32'h400);                           // alias jump, idx 0
        look(32'h100, 0, 0, 32'h0);
        look(32'h140, 1, 1, 32'h400);
        add(1, 32'h104, 1, 1, 0, 1, 32'h100, 32'h80, 0, 0, 32'h0); // rst beats update
        look(32'h100, 0, 0, 32'h0);
        look(32'h140, 0, 0, 32'h0);
        upd(1, 0, 0, 32'h300, 32'h0);                             // not-taken miss
        look(32'h300, 0, 0, 32'h0);
        upd(1, 1, 0, 32'h10C, 32'h44);                            // jump wins over branch
        look(32'h10C, 1, 1, 32'h44);
        add(0, 32'h104, 0, 1, 0, 1, 32'h108, 32'h99C, 0, 0, 32'h0); // upd_valid low
        look(32'h108, 0, 0, 32'h0);
        upd(0, 0, 1, 32'h108, 32'h99C);                           // neither flag
        look(32'h108, 0, 0, 32'h0);
        upd(1, 0, 1, 32'h10C, 32'h48);                            // branch hit retargets
        look(32'h10C, 1, 1, 32'h48);
        upd(1, 0, 0, 32'h10C, 32'h0);
        upd(1, 0, 0, 32'h10C, 32'h0);
        look(32'h10C, 1, 0, 32'h48);                              // is_jump cleared

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].pc, vecs[i].v, vecs[i].br, vecs[i].jp, vecs[i].tk,
                 vecs[i].upc, vecs[i].utgt);
            chk($sformatf("vec%0d_hit", i), s_hit, 32'(vecs[i].e_hit));
            chk($sformatf("vec%0d_taken", i), s_tk, 32'(vecs[i].e_tk));
            chk($sformatf("vec%0d_target", i), s_tgt, vecs[i].e_tgt);
        end

        // Same-cycle jump install and lookup at 0x500
        step(0, 32'h500, 1, 0, 1, 0, 32'h500, 32'h20);
`ifdef BRANCH_PRED_BYPASS_EN
        chk("same_cycle_hit", s_hit, 32'd1);
        chk("same_cycle_target", s_tgt, 32'h20);
`else
        chk("same_cycle_hit", s_hit, 32'd0);
        chk("same_cycle_target", s_tgt, 32'h0);
`endif
        step(0, 32'h500, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("next_cycle_hit", s_hit, 32'd1);
        chk("next_cycle_target", s_tgt, 32'h20);
        // Same-index, different-tag allocation while 0x500 is looked up
        step(0, 32'h500, 1, 1, 0, 1, 32'h600, 32'h30);
`ifdef BRANCH_PRED_BYPASS_EN
        chk("alias_fwd_hit", s_hit, 32'd0);
`else
        chk("alias_fwd_hit", s_hit, 32'd1);
`endif
        step(0, 32'h600, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("alias_after_hit", s_hit, 32'd1);
        chk("alias_after_taken", s_tk, 32'd1);
        chk("alias_after_target", s_tgt, 32'h30);

        // Random traffic over a small PC set to exercise hits, aliasing and saturation
        for (int n = 0; n < 600; n++) begin
            rpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            rupc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            rtgt = $urandom & 32'hFFFF_FFFC;
            step($urandom_range(0, 79) == 0, rpc, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) != 0, rupc, rtgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
